spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_reg_ctrl_if.sv | 23 ++
 rtl/spi_regfile.sv | 33 +++
 rtl/spi_reg_ctrl.sv | 120 ++++++++++++
 tb/tb_spi_reg_ctrl.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI register controller.
package spi_pkg;

  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_RSV_HI  = 6;
  localparam int CMD_RSV_LO  = 4;
  localparam int CMD_ADDR_HI = 3;
  localparam int CMD_ADDR_LO = 0;

  localparam logic [3:0] ADDR_ID     = 4'h0;
  localparam logic [3:0] ADDR_LOCK   = 4'hE;
  localparam logic [3:0] ADDR_STATUS = 4'hF;

  localparam logic [7:0] LOCK_KEY = 8'h5A;

  typedef enum logic {
    IDLE,
    WDATA
  } state_t;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-stream and register-observation bundle between the SPI slave stage and the controller.
interface spi_reg_ctrl_if;

  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         wr_stb;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;
  logic [127:0] regs_q;
  logic         err;

  modport master (
    output rx_data, rx_valid,
    input  tx_data, wr_stb, wr_addr, wr_data, regs_q, err
  );

  modport slave (
    input  rx_data, rx_valid,
    output tx_data, wr_stb, wr_addr, wr_data, regs_q, err
  );

endinterface

// File: rtl/spi_regfile.sv
// 16x8 register map: byte 0 is the ID, byte 15 the status, bytes 1-14 are storage.
module spi_regfile
  import spi_pkg::*;
(
  input  logic         sclk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  logic [7:0]   wdata,
  input  logic [7:0]   id_byte,
  input  logic [7:0]   status_byte,
  output logic [127:0] rd_flat
);

  logic [7:0] mem [16];

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (we && waddr != ADDR_ID && waddr != ADDR_STATUS) begin
      mem[waddr] <= wdata;
    end
  end

  // ID and status are not stored here; they are overlaid on the read bus.
  always_comb begin
    rd_flat = '0;
    for (int i = 1; i < 15; i++) rd_flat[8*i +: 8] = mem[i];
    rd_flat[7:0]     = id_byte;
    rd_flat[127:120] = status_byte;
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command decoder for SPI register access: read/write frames, sticky error, status clear.
// Optional write protection behind reg 0xE when SPI_REG_WPROT_EN is defined.
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter logic [7:0] ID_VAL = 8'hA5
)(
  input  logic sclk,
  input  logic rst_n,
  spi_reg_ctrl_if.slave bus
);

  state_t       state_q, state_d;
  logic [3:0]   addr_q;
  logic [7:0]   tx_q;
  logic         stb_q;
  logic [3:0]   wa_q;
  logic [7:0]   wd_q;
  logic         err_q;
  logic [127:0] regs_flat;

  logic [2:0] cmd_rsv;
  logic [3:0] cmd_addr;
  logic       addr_load, tx_load, commit, rf_we, err_set, err_clr;

  assign cmd_rsv  = bus.rx_data[CMD_RSV_HI:CMD_RSV_LO];
  assign cmd_addr = bus.rx_data[CMD_ADDR_HI:CMD_ADDR_LO];

`ifdef SPI_REG_WPROT_EN
  logic [7:0] lock_val;
  assign lock_val = regs_flat[{ADDR_LOCK, 3'b000} +: 8];
`endif

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    addr_load = 1'b0;
    tx_load   = 1'b0;
    commit    = 1'b0;
    rf_we     = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    if (bus.rx_valid) begin
      case (state_q)
        IDLE: begin
          if (cmd_rsv != 3'b000) begin
            err_set = 1'b1;
          end else if (bus.rx_data[CMD_WR_BIT]) begin
            addr_load = 1'b1;
            state_d   = WDATA;
          end else begin
            tx_load = 1'b1;
          end
        end
        WDATA: begin
          state_d = IDLE;
          if (addr_q == ADDR_ID) begin
            err_set = 1'b1;
          end else if (addr_q == ADDR_STATUS) begin
            err_clr = 1'b1;
            commit  = 1'b1;
`ifdef SPI_REG_WPROT_EN
          end else if (addr_q != ADDR_LOCK && lock_val != LOCK_KEY) begin
            err_set = 1'b1;
`endif
          end else begin
            commit = 1'b1;
            rf_we  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status clear wins; the decoder never raises both on one edge anyway.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= 4'h0;
      tx_q   <= 8'h00;
      stb_q  <= 1'b0;
      wa_q   <= 4'h0;
      wd_q   <= 8'h00;
      err_q  <= 1'b0;
    end else begin
      stb_q <= commit;
      if (addr_load) addr_q <= cmd_addr;
      if (tx_load)   tx_q   <= regs_flat[{cmd_addr, 3'b000} +: 8];
      if (commit) begin
        wa_q <= addr_q;
        wd_q <= bus.rx_data;
      end
      if (err_clr)      err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
    end
  end

  spi_regfile u_regfile (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .we          (rf_we),
    .waddr       (addr_q),
    .wdata       (bus.rx_data),
    .id_byte     (ID_VAL),
    .status_byte ({7'd0, err_q}),
    .rd_flat     (regs_flat)
  );

  assign bus.tx_data = tx_q;
  assign bus.wr_stb  = stb_q;
  assign bus.wr_addr = wa_q;
  assign bus.wr_data = wd_q;
  assign bus.regs_q  = regs_flat;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed self-checking bench for spi_reg_ctrl; write strobes are checked against a scoreboard queue.
module tb_spi_reg_ctrl;

  logic sclk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [11:0] exp_q [$];

  spi_reg_ctrl_if bus ();

  spi_reg_ctrl #(.ID_VAL(8'hA5)) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge sclk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge sclk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic writeReg(input logic [3:0] addr, input logic [7:0] data, input bit commits);
    applyStimulus({4'h8, addr});
    if (commits) exp_q.push_back({addr, data});
    applyStimulus(data);
  endtask

  // Every wr_stb must match the oldest expected commit.
  always @(negedge sclk) begin
    if (bus.wr_stb === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("wr_stb_unexpected", {127'd0, bus.wr_stb}, 128'd0);
      end else begin
        checkOutput("wr_commit", {116'd0, bus.wr_addr, bus.wr_data}, {116'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #1;
    checkOutput("rst_tx", {120'd0, bus.tx_data}, 128'h00);
    checkOutput("rst_err", {127'd0, bus.err}, 128'd0);
    checkOutput("rst_stb", {127'd0, bus.wr_stb}, 128'd0);
    checkOutput("rst_regs", bus.regs_q, {8'h00, 112'd0, 8'hA5});
    @(negedge sclk);
    rst_n = 1'b1;

    // ID read
    applyStimulus(8'h00);
    checkOutput("id_read", {120'd0, bus.tx_data}, 128'hA5);
    checkOutput("id_err", {127'd0, bus.err}, 128'd0);
    applyStimulus(8'h00);

    // Plain write and readback
    writeReg(4'h3, 8'h3C, 1'b1);
    checkOutput("reg3_store", {120'd0, bus.regs_q[31:24]}, 128'h3C);
    applyStimulus(8'h00);
    applyStimulus(8'h03);
    checkOutput("reg3_read", {120'd0, bus.tx_data}, 128'h3C);
    applyStimulus(8'h00);

    // Write to ID is an error; status read and clear
    writeReg(4'h0, 8'hFF, 1'b0);
    checkOutput("id_wr_err", {127'd0, bus.err}, 128'd1);
    checkOutput("id_unchanged", {120'd0, bus.regs_q[7:0]}, 128'hA5);
    applyStimulus(8'h0F);
    checkOutput("status_read", {120'd0, bus.tx_data}, 128'h01);
    writeReg(4'hF, 8'h00, 1'b1);
    checkOutput("status_clr", {127'd0, bus.err}, 128'd0);
    applyStimulus(8'h0F);
    checkOutput("status_read0", {120'd0, bus.tx_data}, 128'h00);

    // Reserved bits: error, stay IDLE, next byte is a read
    applyStimulus(8'h45);
    checkOutput("rsv_err", {127'd0, bus.err}, 128'd1);
    applyStimulus(8'h03);
    checkOutput("rsv_then_read", {120'd0, bus.tx_data}, 128'h3C);
    writeReg(4'hF, 8'h00, 1'b1);

    // Reset while waiting for write data aborts the write
    applyStimulus(8'h00);
    applyStimulus(8'h82);
    @(negedge sclk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_tx", {120'd0, bus.tx_data}, 128'h00);
    checkOutput("async_rst_reg3", {120'd0, bus.regs_q[31:24]}, 128'h00);
    @(negedge sclk);
    rst_n = 1'b1;
    applyStimulus(8'h77);
    checkOutput("abort_err", {127'd0, bus.err}, 128'd1);
    checkOutput("abort_reg2", {120'd0, bus.regs_q[23:16]}, 128'h00);
    writeReg(4'hF, 8'h00, 1'b1);

`ifdef SPI_REG_WPROT_EN
    writeReg(4'h2, 8'h11, 1'b0);
    checkOutput("wprot_drop_err", {127'd0, bus.err}, 128'd1);
    checkOutput("wprot_drop_reg2", {120'd0, bus.regs_q[23:16]}, 128'h00);
    writeReg(4'hF, 8'h00, 1'b1);
    writeReg(4'hE, 8'h5A, 1'b1);
    writeReg(4'h2, 8'h11, 1'b1);
    checkOutput("wprot_unlock_reg2", {120'd0, bus.regs_q[23:16]}, 128'h11);
    checkOutput("wprot_unlock_err", {127'd0, bus.err}, 128'd0);
`else
    writeReg(4'h2, 8'h11, 1'b1);
    checkOutput("reg2_store", {120'd0, bus.regs_q[23:16]}, 128'h11);
    checkOutput("reg2_err", {127'd0, bus.err}, 128'd0);
    writeReg(4'hE, 8'h5A, 1'b1);
`endif
    checkOutput("regE_store", {120'd0, bus.regs_q[119:112]}, 128'h5A);
    applyStimulus(8'h0E);
    checkOutput("regE_read", {120'd0, bus.tx_data}, 128'h5A);
    applyStimulus(8'h00);

    repeat (3) @(negedge sclk);
    checkOutput("scoreboard_drained", {96'd0, 32'(exp_q.size())}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
